vrp_two2ten_dispatch: RTL and testbench



---
 rtl/vrp_two2ten_dispatch_pkg.sv | 16 +
 rtl/vrp_two2ten_dispatch_if.sv | 33 +++
 rtl/vrp_two2ten_dispatch_fifo.sv | 77 +++++++
 rtl/vrp_two2ten_dispatch.sv | 87 ++++++++
 tb/tb_vrp_two2ten_dispatch.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vrp_two2ten_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vrp_two2ten_dispatch_pkg
// Description : Shared constants and payload type for the return-path dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
package vrp_two2ten_dispatch_pkg;

    localparam int VRP_DISPATCH_N          = 10;
    localparam int VRP_DISPATCH_PLD_WIDTH  = 8;
    localparam int VRP_DISPATCH_FIFO_DEPTH = 4;

    typedef logic [VRP_DISPATCH_PLD_WIDTH-1:0] vrp_dispatch_pld_t;

endpackage
`default_nettype wire

// File: rtl/vrp_two2ten_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module      : vrp_two2ten_dispatch_if
// Description : Two-port response input and N-port per-requester output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface vrp_two2ten_dispatch_if #(
    parameter int N         = 10,
    parameter int PLD_WIDTH = 8
);
    localparam int DST_W = $clog2(N);

    logic [1:0]                     in_vld;
    logic [1:0]                     in_rdy;
    logic [1:0][DST_W-1:0]          in_dst;
    logic [1:0][PLD_WIDTH-1:0]      in_pld;
    logic [N-1:0]                   out_vld;
    logic [N-1:0]                   out_rdy;
    logic [N-1:0][PLD_WIDTH-1:0]    out_pld;
    logic                           err_dst;

    modport master (
        output in_vld, in_dst, in_pld, out_rdy,
        input  in_rdy, out_vld, out_pld, err_dst
    );

    modport slave (
        input  in_vld, in_dst, in_pld, out_rdy,
        output in_rdy, out_vld, out_pld, err_dst
    );

endinterface
`default_nettype wire

// File: rtl/vrp_two2ten_dispatch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vrp_dispatch_fifo
// Description : Two-write / one-read FIFO for a single dispatch destination.
// Revision    : 1.0 - initial release
// ============================================================================
module vrp_dispatch_fifo
    import vrp_two2ten_dispatch_pkg::*;
#(
    parameter  int DEPTH   = VRP_DISPATCH_FIFO_DEPTH,
    parameter  int WIDTH   = VRP_DISPATCH_PLD_WIDTH,
    localparam int c_ptr_w = $clog2(DEPTH),
    localparam int c_cnt_w = $clog2(DEPTH + 1)
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic [1:0]              wr_en,
    input  wire logic [1:0][WIDTH-1:0]   wr_pld,
    input  wire logic                    rd_en,
    output logic                         empty,
    output logic [WIDTH-1:0]             head,
    output logic [c_cnt_w-1:0]           free
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [c_ptr_w-1:0]          wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]          rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w-1:0]          wr_ptr_nxt;
    logic [c_cnt_w-1:0]          cnt_q, cnt_d;
    logic                        deq;

    assign empty = (cnt_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign free  = c_cnt_w'(DEPTH) - cnt_q;
    assign deq   = !empty && rd_en;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        wr_ptr_nxt = wr_ptr_q + c_ptr_w'(1);
        // A lone port-1 write lands at wr_ptr just like a lone port-0 write.
        case (wr_en)
            2'b01: begin
                mem_d[wr_ptr_q] = wr_pld[0];
                wr_ptr_d        = wr_ptr_nxt;
            end
            2'b10: begin
                mem_d[wr_ptr_q] = wr_pld[1];
                wr_ptr_d        = wr_ptr_nxt;
            end
            2'b11: begin
                mem_d[wr_ptr_q]   = wr_pld[0];
                mem_d[wr_ptr_nxt] = wr_pld[1];
                wr_ptr_d          = wr_ptr_q + c_ptr_w'(2);
            end
            default: ;
        endcase
        rd_ptr_d = deq ? (rd_ptr_q + c_ptr_w'(1)) : rd_ptr_q;
        cnt_d    = cnt_q + c_cnt_w'(wr_en[0]) + c_cnt_w'(wr_en[1]) - c_cnt_w'(deq);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vrp_two2ten_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : vrp_two2ten_dispatch
// Description : Routes up to two tagged responses per cycle into N destination FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
module vrp_two2ten_dispatch
    import vrp_two2ten_dispatch_pkg::*;
#(
    parameter  int N          = VRP_DISPATCH_N,
    parameter  int PLD_WIDTH  = VRP_DISPATCH_PLD_WIDTH,
    parameter  int FIFO_DEPTH = VRP_DISPATCH_FIFO_DEPTH,
    localparam int c_dst_w    = $clog2(N),
    localparam int c_dst_xw   = c_dst_w + 1,
    localparam int c_cnt_w    = $clog2(FIFO_DEPTH + 1)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    vrp_two2ten_dispatch_if.slave  bus
);

    localparam logic [c_dst_xw-1:0] c_n = c_dst_xw'(N);

    logic [c_cnt_w-1:0]            w_free [N];
    logic [1:0]                    w_wr_en [N];
    logic [N-1:0]                  w_empty;
    logic [N-1:0][PLD_WIDTH-1:0]   w_head;
    logic [c_cnt_w-1:0]            w_free0, w_free1;
    logic [1:0]                    w_oor;
    logic [1:0]                    w_rdy;
    logic [1:0]                    w_acc;
    logic                          w_same;
    logic                          err_dst_q, err_dst_d;

    always_comb begin
        w_oor[0] = {1'b0, bus.in_dst[0]} >= c_n;
        w_oor[1] = {1'b0, bus.in_dst[1]} >= c_n;
        w_free0  = '0;
        w_free1  = '0;
        for (int d = 0; d < N; d++) begin
            if (bus.in_dst[0] == c_dst_w'(d)) w_free0 = w_free[d];
            if (bus.in_dst[1] == c_dst_w'(d)) w_free1 = w_free[d];
        end
        // Port 1 reserves room for port 0's slot whenever port 0 is offering
        // to the same destination, even if port 0 ends up not transferring.
        w_same   = bus.in_vld[0] && (bus.in_dst[0] == bus.in_dst[1]);
        w_rdy[0] = w_oor[0] || (w_free0 >= c_cnt_w'(1));
        w_rdy[1] = w_oor[1] || (w_free1 >= (w_same ? c_cnt_w'(2) : c_cnt_w'(1)));
        w_acc    = bus.in_vld & w_rdy;
        for (int d = 0; d < N; d++) begin
            w_wr_en[d] = {w_acc[1] && (bus.in_dst[1] == c_dst_w'(d)),
                          w_acc[0] && (bus.in_dst[0] == c_dst_w'(d))};
        end
        err_dst_d = err_dst_q || (w_acc[0] && w_oor[0]) || (w_acc[1] && w_oor[1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_dst_q <= 1'b0;
        end else begin
            err_dst_q <= err_dst_d;
        end
    end

    for (genvar d = 0; d < N; d++) begin : g_fifo
        vrp_dispatch_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (PLD_WIDTH)
        ) u_fifo (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (w_wr_en[d]),
            .wr_pld (bus.in_pld),
            .rd_en  (bus.out_rdy[d]),
            .empty  (w_empty[d]),
            .head   (w_head[d]),
            .free   (w_free[d])
        );
    end

    assign bus.in_rdy  = w_rdy;
    assign bus.out_vld = ~w_empty;
    assign bus.out_pld = w_head;
    assign bus.err_dst = err_dst_q;

endmodule
`default_nettype wire

// File: tb/tb_vrp_two2ten_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_vrp_two2ten_dispatch
// Description : Directed scenarios plus randomized traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vrp_two2ten_dispatch;

    localparam int N     = 10;
    localparam int PW    = 8;
    localparam int DEPTH = 4;
    localparam int DW    = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vrp_two2ten_dispatch_if #(.N(N), .PLD_WIDTH(PW)) ifc ();

    vrp_two2ten_dispatch #(.N(N), .PLD_WIDTH(PW), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int errors = 0;
    int checks = 0;

    logic [PW-1:0] mq [N][$];
    logic          m_err;

    task automatic drive(input logic [1:0] vld, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic [PW-1:0] p0, input logic [PW-1:0] p1, input logic [N-1:0] ordy);
        ifc.in_vld    = vld;
        ifc.in_dst[0] = d0;
        ifc.in_dst[1] = d1;
        ifc.in_pld[0] = p0;
        ifc.in_pld[1] = p1;
        ifc.out_rdy   = ordy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(2'b00, '0, '0, '0, '0, '0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        drive(2'b00, DW'(3), DW'(8), '0, '0, '0);
        #1;
        checks++; if (ifc.out_vld !== '0) begin errors++; $display("FAIL reset_out_vld: got %b want 0", ifc.out_vld); end
        checks++; if (ifc.err_dst !== 1'b0) begin errors++; $display("FAIL reset_err_dst: got %b want 0", ifc.err_dst); end
        checks++; if (ifc.in_rdy !== 2'b11) begin errors++; $display("FAIL reset_in_rdy: got %b want 11", ifc.in_rdy); end
    endtask

    task automatic test_single();
        apply_reset();
        drive(2'b01, DW'(3), '0, 8'hA5, '0, '0);
        #1;
        checks++; if (ifc.in_rdy[0] !== 1'b1) begin errors++; $display("FAIL single_rdy: got %b want 1", ifc.in_rdy[0]); end
        next_cycle();
        drive(2'b00, DW'(3), '0, '0, '0, '0);
        #1;
        checks++; if (ifc.out_vld !== 10'b00_0000_1000) begin errors++; $display("FAIL single_vld: got %b want 0000001000", ifc.out_vld); end
        checks++; if (ifc.out_pld[3] !== 8'hA5) begin errors++; $display("FAIL single_pld: got %h want a5", ifc.out_pld[3]); end
        next_cycle();
        checks++; if (ifc.out_pld[3] !== 8'hA5 || ifc.out_vld[3] !== 1'b1) begin errors++; $display("FAIL single_hold: got vld=%b pld=%h want 1/a5", ifc.out_vld[3], ifc.out_pld[3]); end
    endtask

    task automatic test_dual_same();
        logic [PW-1:0] exp_p [2];
        exp_p[0] = 8'h11;
        exp_p[1] = 8'h22;
        apply_reset();
        drive(2'b11, DW'(7), DW'(7), 8'h11, 8'h22, 10'b00_1000_0000);
        #1;
        checks++; if (ifc.in_rdy !== 2'b11) begin errors++; $display("FAIL dual_rdy: got %b want 11", ifc.in_rdy); end
        next_cycle();
        drive(2'b00, DW'(7), DW'(7), '0, '0, 10'b00_1000_0000);
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (ifc.out_vld !== 10'b00_1000_0000 || ifc.out_pld[7] !== exp_p[k]) begin
                errors++; $display("FAIL dual_out%0d: got vld=%b pld=%h want 0010000000/%h", k, ifc.out_vld, ifc.out_pld[7], exp_p[k]);
            end
            next_cycle();
        end
        checks++; if (ifc.out_vld !== '0) begin errors++; $display("FAIL dual_drained: got %b want 0", ifc.out_vld); end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, DW'(2), '0, PW'(8'h30 + i), '0, '0);
            #1;
            checks++; if (ifc.in_rdy[0] !== 1'b1) begin errors++; $display("FAIL full_fill%0d: got %b want 1", i, ifc.in_rdy[0]); end
            next_cycle();
        end
        drive(2'b00, DW'(2), '0, '0, '0, '0);
        #1;
        checks++; if (ifc.in_rdy[0] !== 1'b0) begin errors++; $display("FAIL full_rdy_low: got %b want 0", ifc.in_rdy[0]); end
        drive(2'b00, DW'(2), '0, '0, '0, 10'b00_0000_0100);
        #1;
        checks++; if (ifc.in_rdy[0] !== 1'b0) begin errors++; $display("FAIL full_no_bypass: got %b want 0", ifc.in_rdy[0]); end
        next_cycle();
        drive(2'b00, DW'(2), '0, '0, '0, '0);
        #1;
        checks++; if (ifc.in_rdy[0] !== 1'b1) begin errors++; $display("FAIL full_rdy_back: got %b want 1", ifc.in_rdy[0]); end
        checks++; if (ifc.out_pld[2] !== 8'h31) begin errors++; $display("FAIL full_head: got %h want 31", ifc.out_pld[2]); end
    endtask

    task automatic test_near_full();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, DW'(5), '0, PW'(8'h50 + i), '0, '0);
            next_cycle();
        end
        drive(2'b11, DW'(5), DW'(5), 8'h53, 8'h54, '0);
        #1;
        checks++; if (ifc.in_rdy !== 2'b01) begin errors++; $display("FAIL near_rdy: got %b want 01", ifc.in_rdy); end
        next_cycle();
        drive(2'b10, DW'(5), DW'(5), '0, 8'h54, '0);
        #1;
        checks++; if (ifc.in_rdy[1] !== 1'b0) begin errors++; $display("FAIL near_p1_full: got %b want 0", ifc.in_rdy[1]); end
        drive(2'b10, DW'(5), DW'(5), '0, 8'h54, 10'b00_0010_0000);
        #1;
        checks++; if (ifc.in_rdy[1] !== 1'b0) begin errors++; $display("FAIL near_no_bypass: got %b want 0", ifc.in_rdy[1]); end
        next_cycle();
        drive(2'b10, DW'(5), DW'(5), '0, 8'h54, '0);
        #1;
        checks++; if (ifc.in_rdy[1] !== 1'b1) begin errors++; $display("FAIL near_p1_retry: got %b want 1", ifc.in_rdy[1]); end
        next_cycle();
        drive(2'b00, DW'(5), DW'(5), '0, '0, 10'b00_0010_0000);
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (ifc.out_vld[5] !== 1'b1 || ifc.out_pld[5] !== PW'(8'h51 + k)) begin
                errors++; $display("FAIL near_order%0d: got vld=%b pld=%h want 1/%h", k, ifc.out_vld[5], ifc.out_pld[5], PW'(8'h51 + k));
            end
            next_cycle();
        end
        checks++; if (ifc.out_vld !== '0) begin errors++; $display("FAIL near_drained: got %b want 0", ifc.out_vld); end
    endtask

    task automatic test_oor();
        apply_reset();
        drive(2'b11, DW'(4), DW'(12), 8'h44, 8'h99, '0);
        #1;
        checks++; if (ifc.in_rdy !== 2'b11) begin errors++; $display("FAIL oor_rdy: got %b want 11", ifc.in_rdy); end
        next_cycle();
        drive(2'b00, '0, '0, '0, '0, '0);
        #1;
        checks++; if (ifc.out_vld !== 10'b00_0001_0000) begin errors++; $display("FAIL oor_vld: got %b want 0000010000", ifc.out_vld); end
        checks++; if (ifc.err_dst !== 1'b1) begin errors++; $display("FAIL oor_err_set: got %b want 1", ifc.err_dst); end
        next_cycle();
        next_cycle();
        checks++; if (ifc.err_dst !== 1'b1) begin errors++; $display("FAIL oor_err_sticky: got %b want 1", ifc.err_dst); end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        checks++; if (ifc.err_dst !== 1'b0) begin errors++; $display("FAIL oor_err_clear: got %b want 0", ifc.err_dst); end
        checks++; if (ifc.out_vld !== '0) begin errors++; $display("FAIL oor_rst_vld: got %b want 0", ifc.out_vld); end
    endtask

    task automatic test_random();
        logic [1:0]    vld, er, acc;
        logic [DW-1:0] d [2];
        logic [PW-1:0] p [2];
        logic [N-1:0]  ordy, ev;
        int            hot, thr, f0, f1;
        bit            do_rst, same;
        apply_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_err = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            do_rst = (cyc == 3001) || (cyc == 7003);
            hot = $urandom_range(0, N - 1);
            thr = ((cyc / 400) % 2 == 0) ? 1 : 3;
            vld = 2'($urandom);
            for (int q = 0; q < 2; q++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 55)      d[q] = DW'(hot);
                else if (r < 62) d[q] = DW'($urandom_range(N, 15));
                else             d[q] = DW'($urandom_range(0, N - 1));
                p[q] = PW'($urandom);
            end
            for (int k = 0; k < N; k++) ordy[k] = ($urandom_range(0, 3) < thr);
            rst = do_rst;
            drive(vld, d[0], d[1], p[0], p[1], ordy);
            #1;
            f0 = (int'(d[0]) < N) ? DEPTH - mq[d[0]].size() : 0;
            f1 = (int'(d[1]) < N) ? DEPTH - mq[d[1]].size() : 0;
            same  = vld[0] && (d[0] == d[1]);
            er[0] = (int'(d[0]) >= N) || (f0 >= 1);
            er[1] = (int'(d[1]) >= N) || (f1 >= (same ? 2 : 1));
            for (int k = 0; k < N; k++) ev[k] = (mq[k].size() > 0);
            if (!do_rst) begin
                checks++; if (ifc.in_rdy !== er) begin errors++; $display("FAIL rnd_in_rdy cyc=%0d: got %b want %b", cyc, ifc.in_rdy, er); end
                checks++; if (ifc.out_vld !== ev) begin errors++; $display("FAIL rnd_out_vld cyc=%0d: got %b want %b", cyc, ifc.out_vld, ev); end
                checks++; if (ifc.err_dst !== m_err) begin errors++; $display("FAIL rnd_err cyc=%0d: got %b want %b", cyc, ifc.err_dst, m_err); end
                for (int k = 0; k < N; k++) begin
                    if (ev[k]) begin
                        checks++; if (ifc.out_pld[k] !== mq[k][0]) begin
                            errors++; $display("FAIL rnd_pld cyc=%0d dst=%0d: got %h want %h", cyc, k, ifc.out_pld[k], mq[k][0]);
                        end
                    end
                end
            end
            @(posedge clk);
            if (do_rst) begin
                for (int k = 0; k < N; k++) mq[k].delete();
                m_err = 1'b0;
            end else begin
                acc = vld & er;
                for (int k = 0; k < N; k++) if (ev[k] && ordy[k]) void'(mq[k].pop_front());
                for (int q = 0; q < 2; q++) begin
                    if (acc[q]) begin
                        if (int'(d[q]) >= N) m_err = 1'b1;
                        else                 mq[d[q]].push_back(p[q]);
                    end
                end
            end
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        drive(2'b00, '0, '0, '0, '0, '0);
        test_reset();
        test_single();
        test_dual_same();
        test_full();
        test_near_full();
        test_oor();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
